sync_debounce_bank: RTL and testbench

//  - WIDTH-channel input conditioner: per-channel multi-flop synchronizer, debounce filter, edge detector.
//  - Successor to the single-bit registered A/B sampling stage, generalised in channel count, sync depth and filtering.
//  - Sits between asynchronous board inputs (buttons/switches) and synchronous control logic.

---
 rtl/sync_debounce_pkg.sv | 8 +
 rtl/debounce_chan.sv | 86 ++++++++
 rtl/sync_debounce_bank.sv | 42 ++++
 tb/tb_sync_debounce_bank.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/sync_debounce_pkg.sv
// sync_debounce_pkg: shared FSM state type and default parameters for the debounce bank.
package sync_debounce_pkg;
  typedef enum logic {IDLE, PENDING} state_e;
  localparam int DEF_WIDTH           = 4;
  localparam int DEF_SYNC_STAGES     = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 8;
  localparam int DEF_GLITCH_W        = 8;
endpackage

// File: rtl/debounce_chan.sv
// debounce_chan: one channel of synchronizer, debounce FSM and edge pulses.
// Optional saturating glitch counter when GLITCH_CNT_EN is defined.
module debounce_chan
  import sync_debounce_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
`ifdef GLITCH_CNT_EN
  , parameter int GLITCH_W      = DEF_GLITCH_W
`endif
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
`ifdef GLITCH_CNT_EN
  , output logic [GLITCH_W-1:0] glitch_cnt
`endif
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic dout_q, dout_d, rise_q, rise_d, fall_q, fall_d, s;
  assign s = sync_q[SYNC_STAGES-1];
  assign sync_d = {sync_q[SYNC_STAGES-2:0], din};
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (s != dout_q) begin
          if (DEBOUNCE_CYCLES == 1) dout_d = s;
          else begin
            state_d = PENDING;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = (s == dout_q || cnt_q == LAST) ? IDLE : PENDING;
        cnt_d   = (s == dout_q || cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
        dout_d  = (s != dout_q && cnt_q == LAST) ? s : dout_q;
      end
    endcase
    rise_d = dout_d & ~dout_q;
    fall_d = ~dout_d & dout_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      state_q <= IDLE;
      cnt_q   <= '0;
      dout_q  <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end
  assign dout = dout_q;
  assign rise = rise_q;
  assign fall = fall_q;
`ifdef GLITCH_CNT_EN
  // An abort is a PENDING cycle where the synchronized level fell back to dout.
  logic abort;
  logic [GLITCH_W-1:0] glitch_q, glitch_d;
  assign abort = (state_q == PENDING) && (s == dout_q);
  always_comb glitch_d = (abort && glitch_q != '1) ? glitch_q + GLITCH_W'(1) : glitch_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) glitch_q <= '0;
    else glitch_q <= glitch_d;
  end
  assign glitch_cnt = glitch_q;
`endif
endmodule

// File: rtl/sync_debounce_bank.sv
// sync_debounce_bank: WIDTH independent debounce channels for asynchronous board inputs.
// Define GLITCH_CNT_EN to add per-channel saturating rejected-glitch counters.
module sync_debounce_bank
  import sync_debounce_pkg::*;
#(
  parameter int WIDTH           = DEF_WIDTH,
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
`ifdef GLITCH_CNT_EN
  , parameter int GLITCH_W      = DEF_GLITCH_W
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
`ifdef GLITCH_CNT_EN
  , output logic [WIDTH*GLITCH_W-1:0] glitch_cnt
`endif
);
  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    debounce_chan #(
      .SYNC_STAGES(SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
`ifdef GLITCH_CNT_EN
      , .GLITCH_W(GLITCH_W)
`endif
    ) u_chan (
      .clk(clk),
      .rst_n(rst_n),
      .din(din[i]),
      .dout(dout[i]),
      .rise(rise[i]),
      .fall(fall[i])
`ifdef GLITCH_CNT_EN
      , .glitch_cnt(glitch_cnt[i*GLITCH_W +: GLITCH_W])
`endif
    );
  end
endmodule

// File: tb/tb_sync_debounce_bank.sv
// tb_sync_debounce_bank: directed and randomized checks of the debounce bank against a run-length model.
module tb_sync_debounce_bank;
  localparam int W = 4, SS = 2, DC = 4, GW = 3;
  logic clk = 1'b0;
  logic rst_n;
  logic [W-1:0] din, dout, rise, fall;
`ifdef GLITCH_CNT_EN
  logic [W*GW-1:0] glitch_cnt;
`endif
  sync_debounce_bank #(
    .WIDTH(W), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DC)
`ifdef GLITCH_CNT_EN
    , .GLITCH_W(GW)
`endif
  ) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .dout(dout), .rise(rise), .fall(fall)
`ifdef GLITCH_CNT_EN
    , .glitch_cnt(glitch_cnt)
`endif
  );
  always #5 clk = ~clk;
  logic [W-1:0] m_sync [SS];
  logic [W-1:0] m_dout, m_rise, m_fall;
  int m_run [W];
  int m_gl [W];
  int n_pass = 0, n_total = 0;
  task automatic model_reset();
    for (int k = 0; k < SS; k++) m_sync[k] = '0;
    m_dout = '0; m_rise = '0; m_fall = '0;
    for (int i = 0; i < W; i++) begin m_run[i] = 0; m_gl[i] = 0; end
  endtask
  // A level at the synchronizer output must differ from dout for DC consecutive edges to be accepted.
  task automatic model_edge();
    logic [W-1:0] s;
    s = m_sync[SS-1];
    m_rise = '0; m_fall = '0;
    for (int i = 0; i < W; i++) begin
      if (s[i] != m_dout[i]) begin
        m_run[i]++;
        if (m_run[i] == DC) begin
          m_dout[i] = s[i]; m_rise[i] = s[i]; m_fall[i] = !s[i]; m_run[i] = 0;
        end
      end else begin
        if (m_run[i] > 0 && m_gl[i] < (1 << GW) - 1) m_gl[i]++;
        m_run[i] = 0;
      end
    end
    for (int k = SS - 1; k > 0; k--) m_sync[k] = m_sync[k-1];
    m_sync[0] = din;
  endtask
  function automatic logic [W*GW-1:0] m_gl_vec();
    logic [W*GW-1:0] v;
    for (int i = 0; i < W; i++) v[i*GW +: GW] = GW'(m_gl[i]);
    return v;
  endfunction
  task automatic tick(input logic [W-1:0] d, input logic r);
    @(negedge clk);
    din = d; rst_n = r;
    if (!r) model_reset();
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
  endtask
  task automatic test_reset();
    for (int k = 0; k < 5; k++) begin
      tick(4'hF, 1'b0);
      n_total++;
      if ({dout, rise, fall} !== 12'h0) $display("FAIL reset_outs k=%0d got=%h want=000", k, {dout, rise, fall});
      else n_pass++;
`ifdef GLITCH_CNT_EN
      n_total++;
      if (glitch_cnt !== '0) $display("FAIL reset_glitch got=%h want=0", glitch_cnt);
      else n_pass++;
`endif
    end
    tick(4'h0, 1'b1);
    tick(4'h0, 1'b1);
  endtask
  task automatic test_latency();
    for (int k = 0; k < 8; k++) begin
      tick(4'b0001, 1'b1);
      n_total++;
      if (dout[0] !== (k >= 5) || rise[0] !== (k == 5) || fall[0] !== 1'b0)
        $display("FAIL latency E%0d got dout=%b rise=%b fall=%b want dout=%b rise=%b fall=0", k, dout[0], rise[0], fall[0], k >= 5, k == 5);
      else n_pass++;
      n_total++;
      if ({dout, rise, fall} !== {m_dout, m_rise, m_fall}) $display("FAIL latency_model got=%h want=%h", {dout, rise, fall}, {m_dout, m_rise, m_fall});
      else n_pass++;
    end
  endtask
  task automatic test_glitch_reject();
    for (int k = 0; k < 10; k++) begin
      tick(k < 3 ? 4'b0011 : 4'b0001, 1'b1);
      n_total++;
      if ({dout[1], rise[1], fall[1]} !== 3'b000) $display("FAIL glitch_ch1 k=%0d got=%b want=000", k, {dout[1], rise[1], fall[1]});
      else n_pass++;
    end
`ifdef GLITCH_CNT_EN
    n_total++;
    if (glitch_cnt[GW +: GW] !== GW'(1)) $display("FAIL glitch_cnt_ch1 got=%0d want=1", glitch_cnt[GW +: GW]);
    else n_pass++;
`endif
  endtask
  task automatic test_simultaneous();
    for (int k = 0; k < 8; k++) begin
      tick(4'b0000, 1'b1);
      n_total++;
      if ({dout, rise, fall} !== {m_dout, m_rise, m_fall}) $display("FAIL settle_model got=%h want=%h", {dout, rise, fall}, {m_dout, m_rise, m_fall});
      else n_pass++;
    end
    for (int k = 0; k < 8; k++) begin
      tick(4'b1010, 1'b1);
      n_total++;
      if (dout !== (k >= 5 ? 4'b1010 : 4'b0000) || rise !== (k == 5 ? 4'b1010 : 4'b0000) || fall !== 4'b0000)
        $display("FAIL simul_rise E%0d got dout=%b rise=%b fall=%b", k, dout, rise, fall);
      else n_pass++;
    end
    for (int k = 0; k < 8; k++) begin
      tick(4'b0000, 1'b1);
      n_total++;
      if (dout !== (k >= 5 ? 4'b0000 : 4'b1010) || fall !== (k == 5 ? 4'b1010 : 4'b0000) || rise !== 4'b0000)
        $display("FAIL simul_fall E%0d got dout=%b rise=%b fall=%b", k, dout, rise, fall);
      else n_pass++;
    end
  endtask
  task automatic test_reset_mid_pending();
    for (int k = 0; k < 3; k++) tick(4'b0100, 1'b1);
    for (int k = 0; k < 2; k++) begin
      tick(4'b0100, 1'b0);
      n_total++;
      if ({dout, rise, fall} !== 12'h0) $display("FAIL midreset_held got=%h want=000", {dout, rise, fall});
      else n_pass++;
    end
    for (int k = 0; k < 8; k++) begin
      tick(4'b0100, 1'b1);
      n_total++;
      if (dout[2] !== (k >= 5) || rise[2] !== (k == 5) || fall !== 4'b0000)
        $display("FAIL midreset_requal E%0d got dout=%b rise=%b fall=%b want dout=%b rise=%b", k, dout[2], rise[2], fall, k >= 5, k == 5);
      else n_pass++;
    end
`ifdef GLITCH_CNT_EN
    n_total++;
    if (glitch_cnt !== '0) $display("FAIL midreset_glitch got=%h want=0", glitch_cnt);
    else n_pass++;
`endif
  endtask
  task automatic test_glitch_saturate();
    for (int g = 0; g < 9; g++) begin
      for (int k = 0; k < 6; k++) begin
        tick(k < 2 ? 4'b1100 : 4'b0100, 1'b1);
        n_total++;
        if ({dout[3], rise[3], fall[3]} !== 3'b000) $display("FAIL sat_ch3 g=%0d got=%b want=000", g, {dout[3], rise[3], fall[3]});
        else n_pass++;
      end
`ifdef GLITCH_CNT_EN
      n_total++;
      if (glitch_cnt[3*GW +: GW] !== GW'(g < 7 ? g + 1 : 7)) $display("FAIL sat_cnt g=%0d got=%0d want=%0d", g, glitch_cnt[3*GW +: GW], g < 7 ? g + 1 : 7);
      else n_pass++;
`endif
    end
  endtask
  task automatic test_random();
    logic [W-1:0] d, flip;
    d = din;
    for (int t = 0; t < 400; t++) begin
      for (int i = 0; i < W; i++) flip[i] = ($urandom_range(0, 3) == 0);
      d = d ^ flip;
      tick(d, $urandom_range(0, 149) != 0);
      n_total++;
      if ({dout, rise, fall} !== {m_dout, m_rise, m_fall} || (rise & fall) !== 4'b0000)
        $display("FAIL random t=%0d got=%h want=%h", t, {dout, rise, fall}, {m_dout, m_rise, m_fall});
      else n_pass++;
`ifdef GLITCH_CNT_EN
      n_total++;
      if (glitch_cnt !== m_gl_vec()) $display("FAIL random_glitch t=%0d got=%h want=%h", t, glitch_cnt, m_gl_vec());
      else n_pass++;
`endif
    end
  endtask
  initial begin
    rst_n = 1'b0;
    din = 4'hF;
    model_reset();
    test_reset();
    test_latency();
    test_glitch_reject();
    test_simultaneous();
    test_reset_mid_pending();
    test_glitch_saturate();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
